uart_echo_checker: RTL and testbench
====================================

# uart_echo_checker

Host-side initiator for the UART echo/crosscheck path: serializes a test byte onto `txd` and deserializes the device's reply from `rxd`. It compares the reply against the transform the device applies, which is the low nibble doubled modulo 16. It keeps pass/fail/timeout counters. It sits on the bench/host FPGA opposite the transceiver, or drives it in loopback regression. It contains its own bit-period timing, TX serializer, RX deserializer and sequencing FSM.

## Interface
- `CLK_FREQ`, 50000000, clock frequency in Hz
- `BAUD_RATE`, 115200, line rate; `BIT_CYCLES = CLK_FREQ/BAUD_RATE` (434 at defaults)
- `TIMEOUT_BITS`, 40, bit periods, measured from start acceptance, allowed before the reply start bit is detected

Ports:
- `clk`  in  1  system clock; one clock domain
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  pulse that begins one test; ignored while `busy`
- `test_byte`  in  8  byte to send; captured when `start` is accepted
- `txd`  out  1  UART TX line, idle high
- `rxd`  in  1  UART RX line from the device; asynchronous
- `busy`  out  1  test in progress
- `done`  out  1  one-cycle pulse when the result is valid
- `pass`  out  1  last result matched
- `fail`  out  1  last result mismatched, framing error, or timeout
- `timeout`  out  1  last failure was a timeout
- `frame_err`  out  1  last failure was a stop bit sampled low
- `expected`  out  8  expected reply for the current/last test
- `echo_byte`  out  8  last received reply
- `pass_count`  out  16  saturating count of passes
- `fail_count`  out  16  saturating count of failures

## Operation
- Reset values:
  - `txd`=1; `busy`/`done`/`pass`/`fail`/`timeout`/`frame_err`=0.
  - `expected`/`echo_byte`=0x00; counters=0.
  - `rxd` synchronizer flops = 1.
  - FSM = IDLE.
- Frame format: 8N1, LSB first. Start bit 0, 8 data bits, stop bit 1, each exactly `BIT_CYCLES` clocks.
- Expected value: `expected = {4'b0000, test_byte[2:0], 1'b0}`. This is the 4-bit result of nibble×2; bit 3 of the nibble is discarded.
- `rxd` passes through a 2-flop synchronizer before any use.
- FSM states:
  - **IDLE**: accepts `start`. On accept: capture `test_byte`, load `expected`, clear `pass`/`fail`/`timeout`/`frame_err`, arm TX and RX, start the timeout counter, go to ACTIVE.
  - **ACTIVE**: TX and RX run concurrently. The RX hunt is armed from start acceptance because the device may reply before our stop bit ends.
    - TX: counter per bit; TX completion is set after the stop bit's final cycle.
    - RX hunt: a synchronized falling edge starts the frame; the counter runs to `BIT_CYCLES/2`, then the start bit is re-checked.
      - If the start bit reads high, it is a false start: resume the hunt with no failure.
      - Otherwise sample the data bits, then the stop bit, each `BIT_CYCLES` apart at mid-bit.
    - Timeout counter: counts only while RX is hunting. On reaching `TIMEOUT_BITS*BIT_CYCLES`, mark a timeout. Once a start bit is validated the frame always completes and the timeout is disabled.
    - Leave ACTIVE when TX is complete AND (RX frame complete OR timeout marked).
  - **REPORT** (one cycle): update the result outputs, pulse `done`, increment one counter (saturating at 0xFFFF), then go to IDLE.
- Result priority:
  1. timeout → `fail`=1, `timeout`=1
  2. stop bit low → `fail`=1, `frame_err`=1, `echo_byte` updated
  3. `echo_byte == expected` → `pass`=1
  4. otherwise `fail`=1
- In IDLE, RX is disarmed: unsolicited traffic on `rxd` is ignored and does not corrupt `echo_byte`.
- `start` during ACTIVE or REPORT is dropped, not queued.

## Timing
- `start` sampled high in IDLE at edge N:
  - `busy`=1 and `txd`=0 from N+1.
  - The start bit spans N+1..N+`BIT_CYCLES`.
  - Data bit k is driven from N+1+(k+1)·`BIT_CYCLES`.
  - Stop bit ends at N+10·`BIT_CYCLES`.
  - TX is complete at N+10·`BIT_CYCLES`+1.
- RX: a falling edge seen on the synchronizer output at cycle E gives a start check at E+`BIT_CYCLES/2` and data bit k sampled at E+`BIT_CYCLES/2`+(k+1)·`BIT_CYCLES`. The stop sample comes one bit after data bit 7.
- Let C be the cycle the exit condition is met. REPORT is at C+1, with `done`=1 and the result/counter outputs valid. At C+2, `busy`=0 and the FSM is in IDLE; `start` is accepted there.
- The result outputs hold until the next accepted `start`.
- `rst` asserted at any cycle: all outputs reach their reset values at the next edge. `txd` returns high even mid-frame, and no `done` is produced.

## Test plan
- Loopback with a model device replying `{4'b0, b[2:0], 1'b0}` ~1 bit after our stop bit. Send 0x5A → `echo_byte`=0x04, `pass`=1, `pass_count`=1. Send 0x37 → reply 0x0E, `pass`=1. Send 0x0F → reply 0x0E, `pass`=1.
- Model replies 0x05 to 0x5A → `fail`=1, `timeout`=0, `frame_err`=0, `echo_byte`=0x05, `fail_count`=1.
- `rxd` held high → `done` at N+`TIMEOUT_BITS`·`BIT_CYCLES`+2, with `fail`=1, `timeout`=1, `echo_byte` unchanged.
- Reply 0x04 with its stop bit driven low → `frame_err`=1, `fail`=1. A glitch low shorter than `BIT_CYCLES/2` before the real reply is rejected as a false start and the test still passes.
- Corner cases:
  - `start` pulses during ACTIVE are ignored, giving exactly one `done` per accepted start.
  - `rst` at mid-data-bit drives `txd`=1 next cycle and clears counters.
  - `pass_count` preloaded by forcing it to 0xFFFF stays at 0xFFFF after a further pass.
- Reply begins before our stop bit ends (model replies at the mid-stop sample): the reply is received correctly, and `done` occurs only after both TX and RX complete.

Source files
------------

// File: rtl/uart_echo_checker.sv
// uart_echo_checker: host-side UART echo initiator. Sends one test byte on
// txd, receives the device reply on rxd, compares it against the device
// transform (low nibble doubled modulo 16) and keeps pass/fail counters.
//
// Handshake: start is a request that is accepted only on a cycle where the
// block is idle (busy low). Each accepted start produces exactly one
// single-cycle done pulse, and the result outputs are valid on that cycle.
// They hold until the next accepted start. A start seen while busy is
// dropped, not queued.
module uart_echo_checker #(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD_RATE    = 115200,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  test_byte,
  output logic        txd,
  input  logic        rxd,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic        frame_err,
  output logic [7:0]  expected,
  output logic [7:0]  echo_byte,
  output logic [15:0] pass_count,
  output logic [15:0] fail_count,
  output logic [1:0]  o_dbg_state
);

  localparam int BIT_CYCLES  = CLK_FREQ / BAUD_RATE;
  localparam int HALF_CYCLES = BIT_CYCLES / 2;
  localparam int TO_CYCLES   = TIMEOUT_BITS * BIT_CYCLES;
  localparam int CW          = $clog2(BIT_CYCLES + 1);
  localparam int TW          = $clog2(TO_CYCLES + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TO_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_REPORT} state_t;
  typedef enum logic [1:0] {RX_HUNT, RX_START, RX_DATA, RX_DONE} rx_phase_t;

  state_t       r_state;
  rx_phase_t    r_rx_phase;

  logic         r_rx_s1, r_rx_s2, r_rx_prev;
  logic         r_txd, r_tx_done;
  logic [CW-1:0] r_tx_cnt;
  logic [3:0]   r_tx_idx;
  logic [7:0]   r_tx_shift;
  logic [CW-1:0] r_rx_cnt;
  logic [3:0]   r_rx_idx;
  logic [7:0]   r_rx_shift;
  logic         r_rx_stop_ok;
  logic [TW-1:0] r_to_cnt;
  logic         r_timed_out;

  logic         r_busy, r_done, r_pass, r_fail, r_timeout, r_frame_err;
  logic [7:0]   r_expected, r_echo_byte;
  logic [15:0]  r_pass_count, r_fail_count;

  logic w_accept, w_active, w_rx_fall, w_hunting, w_exit;

  assign w_accept  = (r_state == S_IDLE) && start;
  assign w_active  = (r_state == S_ACTIVE);
  assign w_rx_fall = r_rx_prev && !r_rx_s2;
  assign w_hunting = w_active && (r_rx_phase == RX_HUNT) && !r_timed_out;
  assign w_exit    = w_active && r_tx_done && ((r_rx_phase == RX_DONE) || r_timed_out);

  // Two-flop synchronizer for the asynchronous rxd plus one delay for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_s1   <= 1'b1;
      r_rx_s2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_s1   <= rxd;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
    end
  end

  // TX serializer: start bit, 8 data bits LSB first, stop bit; idle high
  always_ff @(posedge clk) begin
    if (rst) begin
      r_txd      <= 1'b1;
      r_tx_done  <= 1'b0;
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx_shift <= '0;
    end else if (w_accept) begin
      r_txd      <= 1'b0;
      r_tx_done  <= 1'b0;
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx_shift <= test_byte;
    end else if (w_active && !r_tx_done) begin
      if (r_tx_cnt == BIT_LAST) begin
        r_tx_cnt <= '0;
        if (r_tx_idx == 4'd9) begin
          // Stop bit has run its full period
          r_tx_done <= 1'b1;
          r_txd     <= 1'b1;
        end else begin
          r_tx_idx <= r_tx_idx + 4'd1;
          if (r_tx_idx < 4'd8) begin
            r_txd      <= r_tx_shift[0];
            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
          end else begin
            r_txd <= 1'b1;
          end
        end
      end else begin
        r_tx_cnt <= r_tx_cnt + 1'b1;
      end
    end
  end

  // RX deserializer: hunt for a falling edge, confirm start at mid-bit, then sample mid-bit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_phase   <= RX_HUNT;
      r_rx_cnt     <= '0;
      r_rx_idx     <= '0;
      r_rx_shift   <= '0;
      r_rx_stop_ok <= 1'b1;
    end else if (w_accept) begin
      r_rx_phase   <= RX_HUNT;
      r_rx_cnt     <= '0;
      r_rx_idx     <= '0;
      r_rx_stop_ok <= 1'b1;
    end else if (w_active) begin
      case (r_rx_phase)
        RX_HUNT: begin
          // A fall on the same cycle the timeout expires loses to the timeout
          if (w_hunting && (r_to_cnt != TO_LAST) && w_rx_fall) begin
            r_rx_phase <= RX_START;
            r_rx_cnt   <= '0;
          end
        end
        RX_START: begin
          if (r_rx_cnt == HALF_LAST) begin
            r_rx_cnt <= '0;
            r_rx_idx <= '0;
            // High at mid-start means a glitch: go back to hunting silently
            r_rx_phase <= r_rx_s2 ? RX_HUNT : RX_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_rx_cnt == BIT_LAST) begin
            r_rx_cnt <= '0;
            if (r_rx_idx == 4'd8) begin
              r_rx_stop_ok <= r_rx_s2;
              r_rx_phase   <= RX_DONE;
            end else begin
              r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
              r_rx_idx   <= r_rx_idx + 4'd1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        default: r_rx_phase <= RX_DONE;
      endcase
    end
  end

  // Reply timeout: only advances while RX is hunting for a start bit
  always_ff @(posedge clk) begin
    if (rst) begin
      r_to_cnt    <= '0;
      r_timed_out <= 1'b0;
    end else if (w_accept) begin
      r_to_cnt    <= '0;
      r_timed_out <= 1'b0;
    end else if (w_hunting) begin
      if (r_to_cnt == TO_LAST) begin
        r_timed_out <= 1'b1;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

  // Sequencing FSM with registered result outputs and saturating counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_fail       <= 1'b0;
      r_timeout    <= 1'b0;
      r_frame_err  <= 1'b0;
      r_expected   <= '0;
      r_echo_byte  <= '0;
      r_pass_count <= '0;
      r_fail_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            // Device keeps only 3 nibble bits after doubling modulo 16
            r_expected  <= {4'b0000, test_byte[2:0], 1'b0};
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_timeout   <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (w_exit) begin
            r_state <= S_REPORT;
            r_done  <= 1'b1;
            if (r_timed_out) begin
              r_fail    <= 1'b1;
              r_timeout <= 1'b1;
              if (r_fail_count != 16'hFFFF) r_fail_count <= r_fail_count + 16'd1;
            end else if (!r_rx_stop_ok) begin
              r_fail      <= 1'b1;
              r_frame_err <= 1'b1;
              r_echo_byte <= r_rx_shift;
              if (r_fail_count != 16'hFFFF) r_fail_count <= r_fail_count + 16'd1;
            end else begin
              r_echo_byte <= r_rx_shift;
              if (r_rx_shift == r_expected) begin
                r_pass <= 1'b1;
                if (r_pass_count != 16'hFFFF) r_pass_count <= r_pass_count + 16'd1;
              end else begin
                r_fail <= 1'b1;
                if (r_fail_count != 16'hFFFF) r_fail_count <= r_fail_count + 16'd1;
              end
            end
          end
        end
        S_REPORT: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign txd         = r_txd;
  assign busy        = r_busy;
  assign done        = r_done;
  assign pass        = r_pass;
  assign fail        = r_fail;
  assign timeout     = r_timeout;
  assign frame_err   = r_frame_err;
  assign expected    = r_expected;
  assign echo_byte   = r_echo_byte;
  assign pass_count  = r_pass_count;
  assign fail_count  = r_fail_count;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_echo_checker.sv
// Testbench for uart_echo_checker: a model device answers on rxd, and a
// behavioural reference computes expected reply, result flags and counters.
module tb_uart_echo_checker;

  localparam int CLK_FREQ     = 1600;
  localparam int BAUD_RATE    = 100;
  localparam int TIMEOUT_BITS = 40;
  localparam int BC           = CLK_FREQ / BAUD_RATE;
  localparam int TO_CYC       = TIMEOUT_BITS * BC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  test_byte = 8'h00;
  logic        rxd = 1'b1;
  logic        txd, busy, done, pass, fail, timeout, frame_err;
  logic [7:0]  expected, echo_byte;
  logic [15:0] pass_count, fail_count;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  // Reference model state
  int          m_pass = 0;
  int          m_fail = 0;
  logic [7:0]  m_echo = 8'h00;
  logic [7:0]  exp_q[$];

  uart_echo_checker #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE), .TIMEOUT_BITS(TIMEOUT_BITS)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .test_byte(test_byte), .txd(txd),
    .rxd(rxd), .busy(busy), .done(done), .pass(pass), .fail(fail),
    .timeout(timeout), .frame_err(frame_err), .expected(expected),
    .echo_byte(echo_byte), .pass_count(pass_count), .fail_count(fail_count),
    .o_dbg_state(dbg_state)
  );

  // Clock and done-pulse counter
  always #5 clk = ~clk;
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // Device transform: low nibble doubled, modulo 16
  function automatic logic [7:0] model_exp(input logic [7:0] b);
    int v;
    v = b;
    v = ((v % 16) * 2) % 16;
    return v[7:0];
  endfunction

  function automatic logic [9:0] model_tx(input logic [7:0] b);
    logic [9:0] f;
    int v;
    v = b;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = ((v >> i) % 2) == 1;
    f[9] = 1'b1;
    return f;
  endfunction

  // Update the reference for one completed test and return expected flags
  task automatic model_apply(input logic [7:0] b, input logic [7:0] reply,
                             input logic stop_lvl, input bit replied,
                             output logic e_pass, output logic e_fail,
                             output logic e_to, output logic e_fe);
    e_pass = 0; e_fail = 0; e_to = 0; e_fe = 0;
    if (!replied) begin
      e_fail = 1; e_to = 1;
    end else if (stop_lvl == 1'b0) begin
      e_fail = 1; e_fe = 1; m_echo = reply;
    end else begin
      m_echo = reply;
      if (reply == model_exp(b)) e_pass = 1; else e_fail = 1;
    end
    if (e_pass) m_pass = (m_pass < 65535) ? m_pass + 1 : m_pass;
    else        m_fail = (m_fail < 65535) ? m_fail + 1 : m_fail;
  endtask

  // Device driver: one 8N1 frame on rxd, called on a falling edge
  task automatic drive_frame(input logic [7:0] b, input logic stop_lvl);
    rxd = 1'b0;
    repeat (BC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BC) @(negedge clk);
    end
    rxd = stop_lvl;
    repeat (BC) @(negedge clk);
    rxd = 1'b1;
  endtask

  // Issue one start and let the model device respond; lat counts edges after acceptance
  task automatic run_test(input logic [7:0] tbyte, input logic [7:0] reply,
                          input logic stop_lvl, input bit do_reply,
                          input int delay, input int glitch, input bit extra_starts,
                          output int lat, output bit saw, output logic [9:0] tx_bits,
                          output logic busy_n1, output logic busy_after, output int dones);
    int d0;
    exp_q.push_back(model_exp(tbyte));
    d0 = done_cnt;
    tx_bits = '0;
    @(negedge clk);
    start = 1'b1;
    test_byte = tbyte;
    @(posedge clk);
    #1;
    start = 1'b0;
    busy_n1 = busy;
    saw = 0;
    lat = 0;
    fork
      begin
        if (do_reply) begin
          repeat (delay) @(negedge clk);
          if (glitch > 0) begin
            rxd = 1'b0;
            repeat (glitch) @(negedge clk);
            rxd = 1'b1;
            repeat (BC) @(negedge clk);
          end
          drive_frame(reply, stop_lvl);
        end
      end
      begin
        for (int i = 0; i < 1500 && !saw; i++) begin
          @(posedge clk);
          lat++;
          #1;
          if ((lat % BC) == BC / 2 && (lat / BC) < 10) tx_bits[lat / BC] = txd;
          if (done === 1'b1) saw = 1;
        end
      end
      begin
        if (extra_starts) begin
          for (int k = 0; k < 4; k++) begin
            repeat (30) @(negedge clk);
            start = 1'b1;
            test_byte = 8'hFF;
            @(negedge clk);
            start = 1'b0;
          end
        end
      end
    join
    repeat (2) @(negedge clk);
    busy_after = busy;
    dones = done_cnt - d0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (txd !== 1'b1) begin bad++; $display("FAIL reset_txd got=%b exp=1", txd); end
    total++; if ({busy, done, pass, fail, timeout, frame_err} !== 6'b0) begin bad++; $display("FAIL reset_flags got=%b exp=000000", {busy, done, pass, fail, timeout, frame_err}); end
    total++; if (expected !== 8'h00) begin bad++; $display("FAIL reset_expected got=%h exp=00", expected); end
    total++; if (echo_byte !== 8'h00) begin bad++; $display("FAIL reset_echo got=%h exp=00", echo_byte); end
    total++; if (pass_count !== 16'h0 || fail_count !== 16'h0) begin bad++; $display("FAIL reset_counts got=%h/%h exp=0/0", pass_count, fail_count); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_loopback;
    logic [7:0] bytes [3];
    int lat, dn; bit saw; logic [9:0] txb; logic bn1, ba, ep, ef, et, efe; logic [7:0] e;
    bytes[0] = 8'h5A; bytes[1] = 8'h37; bytes[2] = 8'h0F;
    for (int t = 0; t < 3; t++) begin
      run_test(bytes[t], model_exp(bytes[t]), 1'b1, 1, 11 * BC, 0, 0, lat, saw, txb, bn1, ba, dn);
      model_apply(bytes[t], model_exp(bytes[t]), 1'b1, 1, ep, ef, et, efe);
      e = exp_q.pop_front();
      total++; if (!saw) begin bad++; $display("FAIL loop_done b=%h got=none exp=done", bytes[t]); end
      total++; if (bn1 !== 1'b1) begin bad++; $display("FAIL loop_busy_n1 got=%b exp=1", bn1); end
      total++; if (txb !== model_tx(bytes[t])) begin bad++; $display("FAIL loop_txframe b=%h got=%b exp=%b", bytes[t], txb, model_tx(bytes[t])); end
      total++; if (expected !== e) begin bad++; $display("FAIL loop_expected got=%h exp=%h", expected, e); end
      total++; if (echo_byte !== m_echo) begin bad++; $display("FAIL loop_echo got=%h exp=%h", echo_byte, m_echo); end
      total++; if ({pass, fail, timeout, frame_err} !== {ep, ef, et, efe}) begin bad++; $display("FAIL loop_flags got=%b exp=%b", {pass, fail, timeout, frame_err}, {ep, ef, et, efe}); end
      total++; if (pass_count !== 16'(m_pass) || fail_count !== 16'(m_fail)) begin bad++; $display("FAIL loop_counts got=%0d/%0d exp=%0d/%0d", pass_count, fail_count, m_pass, m_fail); end
      total++; if (ba !== 1'b0 || dn != 1) begin bad++; $display("FAIL loop_end busy=%b dones=%0d exp=0/1", ba, dn); end
    end
  endtask

  task automatic test_mismatch;
    int lat, dn; bit saw; logic [9:0] txb; logic bn1, ba, ep, ef, et, efe; logic [7:0] e;
    run_test(8'h5A, 8'h05, 1'b1, 1, 11 * BC, 0, 0, lat, saw, txb, bn1, ba, dn);
    model_apply(8'h5A, 8'h05, 1'b1, 1, ep, ef, et, efe);
    e = exp_q.pop_front();
    total++; if (!saw) begin bad++; $display("FAIL mism_done got=none exp=done"); end
    total++; if ({pass, fail, timeout, frame_err} !== {ep, ef, et, efe}) begin bad++; $display("FAIL mism_flags got=%b exp=%b", {pass, fail, timeout, frame_err}, {ep, ef, et, efe}); end
    total++; if (echo_byte !== m_echo) begin bad++; $display("FAIL mism_echo got=%h exp=%h", echo_byte, m_echo); end
    total++; if (fail_count !== 16'(m_fail)) begin bad++; $display("FAIL mism_failcount got=%0d exp=%0d", fail_count, m_fail); end
    total++; if (expected !== e) begin bad++; $display("FAIL mism_expected got=%h exp=%h", expected, e); end
  endtask

  task automatic test_timeout;
    int lat, dn; bit saw; logic [9:0] txb; logic bn1, ba, ep, ef, et, efe; logic [7:0] e;
    run_test(8'h33, 8'h00, 1'b1, 0, 0, 0, 0, lat, saw, txb, bn1, ba, dn);
    model_apply(8'h33, 8'h00, 1'b1, 0, ep, ef, et, efe);
    e = exp_q.pop_front();
    total++; if (!saw || lat != TO_CYC + 1) begin bad++; $display("FAIL to_latency got=%0d seen=%0d exp=%0d", lat, saw, TO_CYC + 1); end
    total++; if ({pass, fail, timeout, frame_err} !== {ep, ef, et, efe}) begin bad++; $display("FAIL to_flags got=%b exp=%b", {pass, fail, timeout, frame_err}, {ep, ef, et, efe}); end
    total++; if (echo_byte !== m_echo) begin bad++; $display("FAIL to_echo got=%h exp=%h", echo_byte, m_echo); end
    total++; if (fail_count !== 16'(m_fail)) begin bad++; $display("FAIL to_failcount got=%0d exp=%0d", fail_count, m_fail); end
    total++; if (expected !== e) begin bad++; $display("FAIL to_expected got=%h exp=%h", expected, e); end
  endtask

  task automatic test_frame_err;
    int lat, dn; bit saw; logic [9:0] txb; logic bn1, ba, ep, ef, et, efe; logic [7:0] e;
    run_test(8'h5A, 8'h04, 1'b0, 1, 11 * BC, 0, 0, lat, saw, txb, bn1, ba, dn);
    model_apply(8'h5A, 8'h04, 1'b0, 1, ep, ef, et, efe);
    e = exp_q.pop_front();
    total++; if (!saw) begin bad++; $display("FAIL fe_done got=none exp=done"); end
    total++; if ({pass, fail, timeout, frame_err} !== {ep, ef, et, efe}) begin bad++; $display("FAIL fe_flags got=%b exp=%b", {pass, fail, timeout, frame_err}, {ep, ef, et, efe}); end
    total++; if (echo_byte !== m_echo) begin bad++; $display("FAIL fe_echo got=%h exp=%h", echo_byte, m_echo); end
    total++; if (expected !== e) begin bad++; $display("FAIL fe_expected got=%h exp=%h", expected, e); end
  endtask

  task automatic test_glitch;
    int lat, dn; bit saw; logic [9:0] txb; logic bn1, ba, ep, ef, et, efe; logic [7:0] e;
    run_test(8'hC6, model_exp(8'hC6), 1'b1, 1, 11 * BC, 3, 0, lat, saw, txb, bn1, ba, dn);
    model_apply(8'hC6, model_exp(8'hC6), 1'b1, 1, ep, ef, et, efe);
    e = exp_q.pop_front();
    total++; if (!saw) begin bad++; $display("FAIL glitch_done got=none exp=done"); end
    total++; if ({pass, fail, timeout, frame_err} !== {ep, ef, et, efe}) begin bad++; $display("FAIL glitch_flags got=%b exp=%b", {pass, fail, timeout, frame_err}, {ep, ef, et, efe}); end
    total++; if (echo_byte !== m_echo || expected !== e) begin bad++; $display("FAIL glitch_echo got=%h/%h exp=%h/%h", echo_byte, expected, m_echo, e); end
    total++; if (pass_count !== 16'(m_pass)) begin bad++; $display("FAIL glitch_passcount got=%0d exp=%0d", pass_count, m_pass); end
  endtask

  task automatic test_early_reply;
    int lat, dn; bit saw; logic [9:0] txb; logic bn1, ba, ep, ef, et, efe; logic [7:0] e;
    // Reply finishes while our own frame is still on the wire: TX gates done
    run_test(8'h29, model_exp(8'h29), 1'b1, 1, 1, 0, 0, lat, saw, txb, bn1, ba, dn);
    model_apply(8'h29, model_exp(8'h29), 1'b1, 1, ep, ef, et, efe);
    e = exp_q.pop_front();
    total++; if (!saw || lat != 10 * BC + 1) begin bad++; $display("FAIL early_latency got=%0d seen=%0d exp=%0d", lat, saw, 10 * BC + 1); end
    total++; if (pass !== ep || echo_byte !== m_echo || expected !== e) begin bad++; $display("FAIL early_result pass=%b echo=%h exp_pass=%b exp_echo=%h", pass, echo_byte, ep, m_echo); end
    total++; if (txb !== model_tx(8'h29)) begin bad++; $display("FAIL early_txframe got=%b exp=%b", txb, model_tx(8'h29)); end
    // Reply starting at the middle of our stop bit
    run_test(8'h74, model_exp(8'h74), 1'b1, 1, 9 * BC + BC / 2, 0, 0, lat, saw, txb, bn1, ba, dn);
    model_apply(8'h74, model_exp(8'h74), 1'b1, 1, ep, ef, et, efe);
    e = exp_q.pop_front();
    total++; if (!saw || lat <= 10 * BC + 1) begin bad++; $display("FAIL midstop_latency got=%0d seen=%0d exp>%0d", lat, saw, 10 * BC + 1); end
    total++; if (pass !== ep || echo_byte !== m_echo || expected !== e) begin bad++; $display("FAIL midstop_result pass=%b echo=%h exp_pass=%b exp_echo=%h", pass, echo_byte, ep, m_echo); end
  endtask

  task automatic test_back_to_back;
    int lat, dn, d0; bit saw; logic [9:0] txb; logic bn1, ba, ep, ef, et, efe; logic [7:0] e;
    run_test(8'h12, model_exp(8'h12), 1'b1, 1, 11 * BC, 0, 1, lat, saw, txb, bn1, ba, dn);
    model_apply(8'h12, model_exp(8'h12), 1'b1, 1, ep, ef, et, efe);
    e = exp_q.pop_front();
    total++; if (!saw || dn != 1) begin bad++; $display("FAIL b2b_dones got=%0d exp=1", dn); end
    total++; if (expected !== e || pass !== ep) begin bad++; $display("FAIL b2b_result expected=%h pass=%b exp=%h/%b", expected, pass, e, ep); end
    d0 = done_cnt;
    repeat (40) @(negedge clk);
    total++; if (busy !== 1'b0 || done_cnt != d0) begin bad++; $display("FAIL b2b_idle busy=%b extra_dones=%0d exp=0/0", busy, done_cnt - d0); end
  endtask

  task automatic test_idle_ignored;
    int d0;
    d0 = done_cnt;
    @(negedge clk);
    drive_frame(8'h33, 1'b1);
    repeat (4) @(negedge clk);
    total++; if (echo_byte !== m_echo) begin bad++; $display("FAIL idle_echo got=%h exp=%h", echo_byte, m_echo); end
    total++; if (busy !== 1'b0 || done_cnt != d0) begin bad++; $display("FAIL idle_quiet busy=%b dones=%0d exp=0/0", busy, done_cnt - d0); end
  endtask

  task automatic test_random;
    int lat, dn, mode, dly; bit saw; logic [9:0] txb; logic bn1, ba, ep, ef, et, efe;
    logic [7:0] b, r, e; logic sl;
    for (int t = 0; t < 6; t++) begin
      b = 8'($urandom_range(0, 255));
      mode = $urandom_range(0, 2);
      dly = $urandom_range(1, 12 * BC);
      r = (mode == 1) ? 8'($urandom_range(0, 255)) : model_exp(b);
      sl = (mode == 2) ? 1'b0 : 1'b1;
      run_test(b, r, sl, 1, dly, 0, 0, lat, saw, txb, bn1, ba, dn);
      model_apply(b, r, sl, 1, ep, ef, et, efe);
      e = exp_q.pop_front();
      total++; if (!saw || dn != 1) begin bad++; $display("FAIL rnd_done b=%h dones=%0d exp=1", b, dn); end
      total++; if ({pass, fail, timeout, frame_err} !== {ep, ef, et, efe}) begin bad++; $display("FAIL rnd_flags b=%h r=%h got=%b exp=%b", b, r, {pass, fail, timeout, frame_err}, {ep, ef, et, efe}); end
      total++; if (echo_byte !== m_echo || expected !== e) begin bad++; $display("FAIL rnd_bytes got=%h/%h exp=%h/%h", echo_byte, expected, m_echo, e); end
      total++; if (pass_count !== 16'(m_pass) || fail_count !== 16'(m_fail)) begin bad++; $display("FAIL rnd_counts got=%0d/%0d exp=%0d/%0d", pass_count, fail_count, m_pass, m_fail); end
      total++; if (txb !== model_tx(b)) begin bad++; $display("FAIL rnd_txframe b=%h got=%b exp=%b", b, txb, model_tx(b)); end
    end
  endtask

  task automatic test_saturate;
    int lat, dn; bit saw; logic [9:0] txb; logic bn1, ba, ep, ef, et, efe; logic [7:0] e;
    @(negedge clk);
    force dut.r_pass_count = 16'hFFFF;
    @(negedge clk);
    release dut.r_pass_count;
    m_pass = 65535;
    run_test(8'h5A, model_exp(8'h5A), 1'b1, 1, 11 * BC, 0, 0, lat, saw, txb, bn1, ba, dn);
    model_apply(8'h5A, model_exp(8'h5A), 1'b1, 1, ep, ef, et, efe);
    e = exp_q.pop_front();
    total++; if (pass !== ep || pass_count !== 16'(m_pass)) begin bad++; $display("FAIL sat_pass pass=%b count=%h exp=%b/%h", pass, pass_count, ep, 16'(m_pass)); end
    total++; if (fail_count !== 16'(m_fail) || expected !== e) begin bad++; $display("FAIL sat_other fail_count=%0d exp=%0d", fail_count, m_fail); end
  endtask

  task automatic test_reset_mid;
    int d0;
    @(negedge clk);
    start = 1'b1;
    test_byte = 8'h00;
    @(negedge clk);
    start = 1'b0;
    // Land in the middle of data bit 2, which is a 0 on the line
    repeat (3 * BC + BC / 2) @(negedge clk);
    total++; if (txd !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL rstmid_pre txd=%b busy=%b exp=0/1", txd, busy); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    total++; if (txd !== 1'b1) begin bad++; $display("FAIL rstmid_txd got=%b exp=1", txd); end
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rstmid_busy busy=%b done=%b exp=0/0", busy, done); end
    total++; if (pass_count !== 16'h0 || fail_count !== 16'h0) begin bad++; $display("FAIL rstmid_counts got=%h/%h exp=0/0", pass_count, fail_count); end
    m_pass = 0; m_fail = 0; m_echo = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    d0 = done_cnt;
    repeat (12 * BC) @(negedge clk);
    total++; if (done_cnt != d0 || txd !== 1'b1) begin bad++; $display("FAIL rstmid_after dones=%0d txd=%b exp=0/1", done_cnt - d0, txd); end
    total++; if (echo_byte !== m_echo) begin bad++; $display("FAIL rstmid_echo got=%h exp=%h", echo_byte, m_echo); end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_mismatch();
    test_timeout();
    test_frame_err();
    test_glitch();
    test_early_reply();
    test_back_to_back();
    test_idle_ignored();
    test_random();
    test_saturate();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
